// File: rtl/sram_like_arbiter_pkg.sv
// rtl/sram_like_arbiter_pkg.sv - shared encodings for the SRAM-like port arbiter
package sram_like_arbiter_pkg;

  // Arbiter transaction phases: waiting for a grant, issuing, awaiting response
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Transfer size encodings shared by both requester ports and the memory port
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Owner encodings for the single in-flight transaction
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // kseg0/kseg1 are selected by VA[31:30]==2'b10; both alias the low 512 MB
  localparam logic [1:0]  KSEG01_SEL   = 2'b10;
  localparam logic [31:0] KSEG_PA_MASK = 32'h1FFF_FFFF;

endpackage

// File: rtl/sram_like_arbiter_addr_map.sv
// rtl/sram_like_arbiter_addr_map.sv - fixed kseg0/kseg1 virtual to physical translation
module sram_like_arbiter_addr_map
  import sram_like_arbiter_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic [31:0] vaddr_i,
  output logic [31:0] paddr_o
);

  // Unmapped segments drop VA[31:29]; everything else passes through untouched
  always_comb begin
    paddr_o = vaddr_i;
    if (EN && (vaddr_i[31:30] == KSEG01_SEL)) begin
      paddr_o = vaddr_i & KSEG_PA_MASK;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - shares one single-outstanding SRAM-like port between fetch and data
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter bit          ADDR_MAP_EN  = 1'b1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        own_q, own_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        grant_inst;
  logic        grant_data;
  logic [31:0] win_vaddr;
  logic [31:0] win_paddr;
  logic        resp_fire;

  // Grant only from IDLE and never while reset is held, so addr_ok stays low in reset
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if ((state_q == ST_IDLE) && resetn) begin
      if (data_req && !(inst_req && (starve_cnt_q == STARVE_MAX))) begin
        grant_data = 1'b1;
      end else if (inst_req) begin
        grant_inst = 1'b1;
      end
    end
  end

  assign win_vaddr = grant_data ? data_addr : inst_addr;

  sram_like_arbiter_addr_map #(
    .EN (ADDR_MAP_EN)
  ) u_addr_map (
    .vaddr_i (win_vaddr),
    .paddr_o (win_paddr)
  );

  // Next state, request latch on grant, and fetch starvation tracking
  always_comb begin
    state_d      = state_q;
    own_d        = own_q;
    starve_cnt_d = starve_cnt_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_inst || grant_data) begin
          state_d = ST_ADDR;
          own_d   = grant_data ? OWN_DATA : OWN_INST;
          wr_d    = grant_data ? data_wr : inst_wr;
          size_d  = grant_data ? data_size : inst_size;
          addr_d  = win_paddr;
          wdata_d = grant_data ? data_wdata : inst_wdata;
          if (grant_data && inst_req) begin
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = '0;
          end
        end
      end
      ST_ADDR: begin
        if (mem_addr_ok) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (mem_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched request registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      own_q        <= OWN_INST;
      starve_cnt_q <= '0;
      wr_q         <= 1'b0;
      size_q       <= SIZE_B;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      starve_cnt_q <= starve_cnt_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign mem_req   = (state_q == ST_ADDR);
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  // A response only counts while a transaction is awaiting it; strays are dropped
  assign resp_fire    = (state_q == ST_DATA) && mem_data_ok;
  assign inst_data_ok = resp_fire && (own_q == OWN_INST);
  assign data_data_ok = resp_fire && (own_q == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - scoreboard bench for the SRAM-like port arbiter
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  typedef struct packed {
    logic        own;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] vaddr;
    logic [31:0] paddr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  logic        n_inst_addr_ok, n_inst_data_ok, n_data_addr_ok, n_data_data_ok;
  logic [31:0] n_inst_rdata, n_data_rdata;
  logic        n_mem_req, n_mem_wr;
  logic [1:0]  n_mem_size;
  logic [31:0] n_mem_addr, n_mem_wdata;

  always #5 clk = ~clk;

  sram_like_arbiter #(.ADDR_MAP_EN(1'b1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  sram_like_arbiter #(.ADDR_MAP_EN(1'b0), .STARVE_LIMIT(4)) dut_nomap (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(n_inst_addr_ok), .inst_data_ok(n_inst_data_ok),
    .inst_rdata(n_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(n_data_addr_ok), .data_data_ok(n_data_data_ok),
    .data_rdata(n_data_rdata),
    .mem_req(n_mem_req), .mem_wr(n_mem_wr), .mem_size(n_mem_size), .mem_addr(n_mem_addr),
    .mem_wdata(n_mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t inst_q[$];
  exp_t data_q[$];
  exp_t exp_q[$];
  exp_t infl;
  bit   infl_v = 1'b0;
  int   addr_wait = 0;
  int   data_wait = 1;
  int   m_phase = 0;
  int   m_cnt = 0;
  logic [31:0] m_paddr = '0;
  int   both_ok = 0;
  int   inst_ack = 0;
  int   data_ack = 0;
  int   dok_cnt = 0;
  int   req_len = 0;
  int   last_req_len = 0;
  int   acc_cyc[$];
  int   dok_cyc[$];
  int   req_start[$];
  bit   i_acc, d_acc, prev_pend;
  logic [66:0] prev_fields;

  function automatic logic [31:0] rd_of(input logic [31:0] pa);
    return pa ^ 32'h23DD_BFC0;
  endfunction

  function automatic exp_t mk(input logic own, input logic wr, input logic [1:0] size,
                              input logic [31:0] va, input logic [31:0] wd);
    exp_t e;
    e.own   = own;
    e.wr    = wr;
    e.size  = size;
    e.vaddr = va;
    e.paddr = (va[31:30] == 2'b10) ? {3'b000, va[28:0]} : va;
    e.wdata = wd;
    return e;
  endfunction

  task automatic push_req(input exp_t e);
    if (e.own) data_q.push_back(e);
    else       inst_q.push_back(e);
  endtask

  // One clock: monitor/scoreboard at negedge, requester drivers and memory model after posedge
  task automatic cycle();
    logic [1:0]  dok;
    logic [31:0] got;
    @(negedge clk);
    cyc++;
    i_acc = inst_req && inst_addr_ok;
    d_acc = data_req && data_addr_ok;
    if (!resetn) begin
      infl_v = 1'b0; prev_pend = 1'b0; req_len = 0;
    end
    if ((inst_addr_ok && data_addr_ok) || (n_inst_addr_ok && n_data_addr_ok)) both_ok++;
    if (i_acc) inst_ack++;
    if (d_acc) data_ack++;
    if (i_acc || d_acc) acc_cyc.push_back(cyc);
    if (mem_req) begin
      if (req_len == 0) req_start.push_back(cyc);
      req_len++;
      if (prev_pend) begin
        n_vec++;
        if ({mem_wr, mem_size, mem_addr, mem_wdata} !== prev_fields) begin
          n_err++;
          $display("FAIL mem_hold: got %h required %h", {mem_wr, mem_size, mem_addr, mem_wdata}, prev_fields);
        end
      end
    end
    prev_pend   = mem_req && !mem_addr_ok;
    prev_fields = {mem_wr, mem_size, mem_addr, mem_wdata};
    if (mem_req && mem_addr_ok) begin
      last_req_len = req_len;
      req_len = 0;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL mem_issue: unexpected issue addr %h", mem_addr);
      end else begin
        infl = exp_q.pop_front();
        infl_v = 1'b1;
        if ({mem_wr, mem_size, mem_addr, mem_wdata} !== {infl.wr, infl.size, infl.paddr, infl.wdata}) begin
          n_err++;
          $display("FAIL mem_issue: got wr=%b size=%0d addr=%h wdata=%h required wr=%b size=%0d addr=%h wdata=%h",
                   mem_wr, mem_size, mem_addr, mem_wdata, infl.wr, infl.size, infl.paddr, infl.wdata);
        end
        n_vec++;
        if ({n_mem_req, n_mem_wr, n_mem_size, n_mem_addr, n_mem_wdata} !==
            {1'b1, infl.wr, infl.size, infl.vaddr, infl.wdata}) begin
          n_err++;
          $display("FAIL nomap_issue: got addr %h required %h", n_mem_addr, infl.vaddr);
        end
      end
    end
    if (inst_data_ok || data_data_ok) begin
      dok_cnt++;
      dok_cyc.push_back(cyc);
      n_vec++;
      if (!infl_v) begin
        n_err++;
        $display("FAIL resp_spurious: got inst_data_ok=%b data_data_ok=%b required none", inst_data_ok, data_data_ok);
      end else begin
        dok = infl.own ? 2'b01 : 2'b10;
        if ({inst_data_ok, data_data_ok, n_inst_data_ok, n_data_data_ok} !== {dok, dok}) begin
          n_err++;
          $display("FAIL resp_port: got %b required %b", {inst_data_ok, data_data_ok, n_inst_data_ok, n_data_data_ok}, {dok, dok});
        end
        if (!infl.wr) begin
          n_vec++;
          got = infl.own ? data_rdata : inst_rdata;
          if (got !== rd_of(infl.paddr)) begin
            n_err++;
            $display("FAIL resp_rdata: got %h required %h", got, rd_of(infl.paddr));
          end
        end
        infl_v = 1'b0;
      end
    end
    n_vec++;
    if ({inst_data_ok ? 32'h0 : inst_rdata, data_data_ok ? 32'h0 : data_rdata,
         n_inst_data_ok ? 32'h0 : n_inst_rdata, n_data_data_ok ? 32'h0 : n_data_rdata} !== 128'h0) begin
      n_err++;
      $display("FAIL rdata_idle: got inst %h data %h required 0", inst_rdata, data_rdata);
    end

    @(posedge clk);
    #1;
    if (i_acc && inst_q.size() != 0) inst_q.delete(0);
    if (d_acc && data_q.size() != 0) data_q.delete(0);
    if (inst_q.size() != 0) begin
      inst_req = 1'b1; inst_wr = inst_q[0].wr; inst_size = inst_q[0].size;
      inst_addr = inst_q[0].vaddr; inst_wdata = inst_q[0].wdata;
    end else begin
      inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = '0; inst_wdata = '0;
    end
    if (data_q.size() != 0) begin
      data_req = 1'b1; data_wr = data_q[0].wr; data_size = data_q[0].size;
      data_addr = data_q[0].vaddr; data_wdata = data_q[0].wdata;
    end else begin
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    end
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    if (!resetn) begin
      m_phase = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      if (mem_req) begin
        if (m_cnt >= addr_wait) begin
          mem_addr_ok = 1'b1; m_paddr = mem_addr; m_phase = 1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end else begin
      m_cnt++;
      if (m_cnt >= data_wait) begin
        mem_data_ok = 1'b1; mem_rdata = rd_of(m_paddr); m_phase = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    bit busy;
    k = 0;
    busy = 1'b1;
    while (busy && k < budget) begin
      cycle();
      k++;
      busy = (inst_q.size() != 0) || (data_q.size() != 0) || (exp_q.size() != 0) || infl_v;
    end
    n_vec++;
    if (busy) begin
      n_err++;
      $display("FAIL timeout: got %0d pending after %0d cycles required 0", exp_q.size() + int'(infl_v), budget);
      inst_q.delete(); data_q.delete(); exp_q.delete(); infl_v = 1'b0;
    end
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    logic [135:0] snap;
    resetn = 1'b0;
    cycle();
    cycle();
    snap = {mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_addr_ok, data_addr_ok,
            inst_data_ok, data_data_ok, inst_rdata, data_rdata};
    n_vec++;
    if (snap !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", snap);
    end
    resetn = 1'b1;
    cycle();
  endtask

  task automatic test_single_fetch();
    int ia, dc;
    exp_t e;
    addr_wait = 1; data_wait = 2;
    ia = inst_ack; dc = dok_cnt;
    e = mk(OWN_INST, 1'b0, SIZE_W, 32'hBFC0_0000, 32'h0);
    exp_q.push_back(e);
    push_req(e);
    run_until_idle(40);
    n_vec++;
    if ((inst_ack - ia) != 1 || (dok_cnt - dc) != 1) begin
      n_err++;
      $display("FAIL single_fetch_pulses: got addr_ok=%0d data_ok=%0d required 1 1", inst_ack - ia, dok_cnt - dc);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    addr_wait = 0; data_wait = 1;
    acc_cyc.delete(); dok_cyc.delete(); req_start.delete();
    for (int i = 0; i < 2; i++) begin
      e = mk(OWN_DATA, 1'b0, SIZE_W, 32'h8000_0040 + 32'(i * 4), 32'h0);
      exp_q.push_back(e);
      push_req(e);
    end
    run_until_idle(40);
    n_vec++;
    if (acc_cyc.size() != 2 || dok_cyc.size() != 2 || req_start.size() != 2) begin
      n_err++;
      $display("FAIL latency_events: got acc=%0d dok=%0d req=%0d required 2 2 2", acc_cyc.size(), dok_cyc.size(), req_start.size());
    end else begin
      n_vec++;
      if ({req_start[0] - acc_cyc[0], dok_cyc[0] - acc_cyc[0], acc_cyc[1] - acc_cyc[0]} !== {32'd1, 32'd2, 32'd3}) begin
        n_err++;
        $display("FAIL latency: got req+%0d dok+%0d next+%0d required 1 2 3",
                 req_start[0] - acc_cyc[0], dok_cyc[0] - acc_cyc[0], acc_cyc[1] - acc_cyc[0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t ed, ei;
    addr_wait = 1; data_wait = 1;
    ed = mk(OWN_DATA, 1'b0, SIZE_W, 32'h8000_1000, 32'h0);
    ei = mk(OWN_INST, 1'b0, SIZE_W, 32'h0040_0000, 32'h0);
    exp_q.push_back(ed);
    exp_q.push_back(ei);
    push_req(ei);
    push_req(ed);
    run_until_idle(60);
  endtask

  task automatic test_starvation();
    exp_t ei;
    exp_t ed[6];
    addr_wait = 0; data_wait = 1;
    ei = mk(OWN_INST, 1'b0, SIZE_W, 32'hBFC0_0010, 32'h0);
    for (int i = 0; i < 6; i++) ed[i] = mk(OWN_DATA, 1'b0, SIZE_W, 32'h8000_0100 + 32'(i * 4), 32'h0);
    for (int i = 0; i < 4; i++) exp_q.push_back(ed[i]);
    exp_q.push_back(ei);
    exp_q.push_back(ed[4]);
    exp_q.push_back(ed[5]);
    push_req(ei);
    for (int i = 0; i < 6; i++) push_req(ed[i]);
    run_until_idle(120);
  endtask

  task automatic test_write_path();
    int da, dc;
    exp_t e;
    addr_wait = 3; data_wait = 1;
    da = data_ack; dc = dok_cnt;
    e = mk(OWN_DATA, 1'b1, SIZE_W, 32'hA000_2000, 32'hDEAD_BEEF);
    exp_q.push_back(e);
    push_req(e);
    run_until_idle(40);
    n_vec++;
    if (last_req_len != 4 || (data_ack - da) != 1 || (dok_cnt - dc) != 1) begin
      n_err++;
      $display("FAIL write_path: got req_cycles=%0d addr_ok=%0d data_ok=%0d required 4 1 1",
               last_req_len, data_ack - da, dok_cnt - dc);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int k;
    logic [135:0] snap;
    addr_wait = 0; data_wait = 6;
    e = mk(OWN_DATA, 1'b0, SIZE_W, 32'h8000_3000, 32'h0);
    exp_q.push_back(e);
    push_req(e);
    k = 0;
    while (!infl_v && k < 20) begin
      cycle();
      k++;
    end
    n_vec++;
    if (!infl_v) begin
      n_err++;
      $display("FAIL reset_mid_setup: got no issue within 20 cycles required issue");
    end
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hCAFE_0001;
    #1;
    n_vec++;
    if ({data_data_ok, data_rdata} !== {1'b1, 32'hCAFE_0001}) begin
      n_err++;
      $display("FAIL data_phase_resp: got %b %h required 1 cafe0001", data_data_ok, data_rdata);
    end
    resetn = 1'b0;
    #1;
    snap = {mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_addr_ok, data_addr_ok,
            inst_data_ok, data_data_ok, inst_rdata, data_rdata};
    n_vec++;
    if (snap !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %h required 0", snap);
    end
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    cycle();
    cycle();
    resetn = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1234_5678;
    @(negedge clk);
    n_vec++;
    if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== 66'h0) begin
      n_err++;
      $display("FAIL stray_resp: got inst_data_ok=%b data_data_ok=%b required 0 0", inst_data_ok, data_data_ok);
    end
    cycle();
    cycle();
  endtask

  task automatic test_no_map();
    exp_t e;
    addr_wait = 0; data_wait = 1;
    e = mk(OWN_DATA, 1'b0, SIZE_W, 32'hBFAF_8000, 32'h0);
    exp_q.push_back(e);
    push_req(e);
    run_until_idle(40);
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    prev_pend = 1'b0; prev_fields = '0; i_acc = 1'b0; d_acc = 1'b0;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_simultaneous();
    test_starvation();
    test_write_path();
    test_reset_mid();
    test_no_map();
    n_vec++;
    if (both_ok != 0) begin
      n_err++;
      $display("FAIL dual_addr_ok: got %0d cycles required 0", both_ok);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
